// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the result sources and the register-file write-port arbiter.
// The master side is the group of result sources; the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    wb_hold;
    logic [ADDR_W-1:0]       address_d;
    logic [DATA_W-1:0]       data_dval;
    logic                    write_enable;
    logic [2:0]              grant_id;
    logic [2**ADDR_W-1:0]    pending_mask;

    modport master (
        output req_valid, req_addr, req_data, wb_hold,
        input  req_ready, address_d, data_dval, write_enable, grant_id, pending_mask
    );

    modport slave (
        input  req_valid, req_addr, req_data, wb_hold,
        output req_ready, address_d, data_dval, write_enable, grant_id, pending_mask
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register file's single write port among the
// writeback sources. It also produces a registered mask of destination registers that have a write pending.
module regfile_wb_arbiter #(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int ZERO_LOCK = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [2:0] LAST_IDX = 3'(N_REQ - 1);

    logic [PTR_W-1:0]     ptr;
    logic                 gnt_any;
    logic [2:0]           gnt_idx;
    int                   cand;
    logic [N_REQ-1:0]     ready;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_data;
    logic [2**ADDR_W-1:0] pend_nxt;

    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    data_q;
    logic                 we_q;
    logic [2:0]           gid_q;
    logic [2**ADDR_W-1:0] pend_q;

    // The search starts at ptr and wraps. Grant depends only on valid, hold, reset and ptr.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        if (!reset && !bus.wb_hold) begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = (int'(ptr) + k) % N_REQ;
                if (!gnt_any && bus.req_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = 3'(cand);
                end
            end
        end
    end

    always_comb begin
        ready    = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_any && gnt_idx == 3'(i)) begin
                ready[i] = 1'b1;
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        pend_nxt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.req_valid[i]) begin
                pend_nxt[bus.req_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        if (ZERO_LOCK != 0) begin
            pend_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr    <= '0;
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
            gid_q  <= '0;
            pend_q <= '0;
        end else begin
            pend_q <= pend_nxt;
            if (gnt_any) begin
                addr_q <= sel_addr;
                data_q <= sel_data;
                gid_q  <= gnt_idx;
                // A write to r0 is accepted from the source but not issued to the register file.
                we_q   <= !((ZERO_LOCK != 0) && (sel_addr == '0));
                if (gnt_idx == LAST_IDX) begin
                    ptr <= '0;
                end else begin
                    ptr <= PTR_W'(gnt_idx + 3'd1);
                end
            end else begin
                we_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready    = ready;
    assign bus.address_d    = addr_q;
    assign bus.data_dval    = data_q;
    assign bus.write_enable = we_q;
    assign bus.grant_id     = gid_q;
    assign bus.pending_mask = pend_q;
endmodule
